core_param_loader: RTL

- Streaming configuration loader for the reconfigurable RANC core array.
- Takes a narrow valid/ready configuration stream, decodes a header beat per transaction, and assembles CSRAM_WIDTH-bit words from DATA_W-bit beats.
- In write mode, writes the assembled words into one selected core's CSRAM. In read mode, streams a selected CSRAM range back out.
- Sits between the host/config interface and the per-core CSRAM parameter ports; supersedes the single-core, single-word write path.

---
 rtl/core_param_pkg.sv | 44 ++++
 rtl/param_word_serdes.sv | 58 +++++
 rtl/core_param_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_param_pkg.sv
// Shared types and header-layout helpers for the CSRAM parameter loader.
// WRITE_VERIFY_EN adds the read-back verify states to the FSM.
package core_param_pkg;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    localparam int unsigned HDR_MODE_BIT = 0;
    localparam int unsigned HDR_ADDR_LSB = 1;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StWrite,
        StRdReq,
        StRdWait,
        StRdSend,
        StDrain
`ifdef WRITE_VERIFY_EN
        ,
        StVerifyReq,
        StVerifyCmp
`endif
    } state_e;

    function automatic int unsigned hdr_cnt_lsb(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned hdr_core_lsb(input int unsigned addr_w);
        return 2 * addr_w + 1;
    endfunction

    function automatic int unsigned hdr_width(input int unsigned addr_w,
                                              input int unsigned core_w);
        return 2 * addr_w + core_w + 1;
    endfunction

    function automatic int unsigned calc_beats(input int unsigned width,
                                               input int unsigned data_w);
        return (width + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/param_word_serdes.sv
// Beat-index counter plus padded word register: assembles a CSRAM word from beats
// LSB-first, or holds a loaded word and presents it one beat at a time.
module param_word_serdes #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CSRAM_WIDTH = 368,
    parameter int unsigned BEATS       = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   beat_wr_i,
    input  logic                   step_i,
    input  logic                   load_i,
    input  logic [DATA_W-1:0]      beat_i,
    input  logic [CSRAM_WIDTH-1:0] word_i,
    output logic [CSRAM_WIDTH-1:0] word_o,
    output logic [DATA_W-1:0]      beat_o,
    output logic                   last_o
);

    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PAD_W = BEATS * DATA_W;

    logic [PAD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign last_o = (idx_q == IDX_W'(BEATS - 1));
    // Padding above CSRAM_WIDTH is zero after a load, so the final beat reads zero-extended.
    assign word_o = word_q[CSRAM_WIDTH-1:0];
    assign beat_o = word_q[32'(idx_q) * DATA_W +: DATA_W];

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = PAD_W'(word_i);
            idx_d  = '0;
        end else if (beat_wr_i || step_i) begin
            if (beat_wr_i) begin
                word_d[32'(idx_q) * DATA_W +: DATA_W] = beat_i;
            end
            idx_d = last_o ? '0 : idx_q + 1'b1;
        end else if (clear_i) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/core_param_loader.sv
// Streaming CSRAM configuration loader: header-decoded multi-word write or readback
// for one selected core. Define WRITE_VERIFY_EN to read back and compare each written word.
module core_param_loader
    import core_param_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 9,
    parameter int unsigned CSRAM_WIDTH = 368,
    parameter int unsigned NUM_NEURONS = 256,
    parameter int unsigned DATA_W      = 32,
    localparam int unsigned ADDR_W     = $clog2(NUM_NEURONS),
    localparam int unsigned CORE_W     = $clog2(NUM_CORES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [DATA_W-1:0]                cfg_data,
    output logic [NUM_CORES-1:0]             param_wen,
    output logic [NUM_CORES-1:0]             param_ren,
    output logic [ADDR_W-1:0]                param_addr,
    output logic [CSRAM_WIDTH-1:0]           param_data_out,
    input  logic [NUM_CORES*CSRAM_WIDTH-1:0] param_data_in,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int unsigned BEATS    = calc_beats(CSRAM_WIDTH, DATA_W);
    localparam int unsigned CNT_LSB  = hdr_cnt_lsb(ADDR_W);
    localparam int unsigned CORE_LSB = hdr_core_lsb(ADDR_W);

    state_e                 state_q, state_d, next_st;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W-1:0]      left_q, left_d;
    logic [CORE_W-1:0]      core_q, core_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [CSRAM_WIDTH-1:0] pdata_q, pdata_d;

    logic                   hdr_mode;
    logic [ADDR_W-1:0]      hdr_addr, hdr_cnt_m1;
    logic [CORE_W-1:0]      hdr_core;
    logic [ADDR_W+1:0]      hdr_end;
    logic                   hdr_ok;

    logic                   ready_st, word_end;
    logic                   ser_clear, ser_wr, ser_step, ser_load, ser_last;
    logic [CSRAM_WIDTH-1:0] ser_word, rd_word;
    logic [DATA_W-1:0]      ser_beat;
    logic [NUM_CORES-1:0]   core_oh;

    assign hdr_mode   = cfg_data[HDR_MODE_BIT];
    assign hdr_addr   = cfg_data[HDR_ADDR_LSB +: ADDR_W];
    assign hdr_cnt_m1 = cfg_data[CNT_LSB +: ADDR_W];
    assign hdr_core   = cfg_data[CORE_LSB +: CORE_W];
    assign hdr_end    = {2'b00, hdr_addr} + {2'b00, hdr_cnt_m1} + (ADDR_W + 2)'(1);
    assign hdr_ok     = (32'(hdr_core) < NUM_CORES) && (hdr_end <= (ADDR_W + 2)'(NUM_NEURONS));

    assign core_oh = NUM_CORES'(1) << core_q;
    assign rd_word = param_data_in[32'(core_q) * CSRAM_WIDTH +: CSRAM_WIDTH];

    param_word_serdes #(
        .DATA_W     (DATA_W),
        .CSRAM_WIDTH(CSRAM_WIDTH),
        .BEATS      (BEATS)
    ) u_serdes (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (ser_clear),
        .beat_wr_i(ser_wr),
        .step_i   (ser_step),
        .load_i   (ser_load),
        .beat_i   (cfg_data),
        .word_i   (rd_word),
        .word_o   (ser_word),
        .beat_o   (ser_beat),
        .last_o   (ser_last)
    );

    always_comb begin
        state_d   = state_q;
        next_st   = StIdle;
        addr_d    = addr_q;
        left_d    = left_q;
        core_d    = core_q;
        err_d     = err_q;
        done_d    = 1'b0;
        pdata_d   = pdata_q;
        ready_st  = 1'b0;
        word_end  = 1'b0;
        ser_clear = 1'b0;
        ser_wr    = 1'b0;
        ser_step  = 1'b0;
        ser_load  = 1'b0;
        param_wen = '0;
        param_ren = '0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;

        case (state_q)
            StIdle: begin
                ready_st = 1'b1;
                if (cfg_valid && cfg_ready) begin
                    ser_clear = 1'b1;
                    addr_d    = hdr_addr;
                    left_d    = hdr_cnt_m1;
                    core_d    = hdr_core;
                    err_d     = !hdr_ok;
                    if (hdr_mode == MODE_READ) begin
                        if (hdr_ok) state_d = StRdReq;
                        else        done_d  = 1'b1;
                    end else begin
                        state_d = hdr_ok ? StLoad : StDrain;
                    end
                end
            end
            StLoad: begin
                ready_st = 1'b1;
                if (cfg_valid && cfg_ready) begin
                    ser_wr = 1'b1;
                    if (ser_last) state_d = StWrite;
                end
            end
            StWrite: begin
                param_wen = core_oh;
                pdata_d   = ser_word;
`ifdef WRITE_VERIFY_EN
                state_d   = StVerifyReq;
            end
            StVerifyReq: begin
                param_ren = core_oh;
                state_d   = StVerifyCmp;
            end
            StVerifyCmp: begin
                if (rd_word != pdata_q) err_d = 1'b1;
                word_end = 1'b1;
                next_st  = StLoad;
`else
                word_end  = 1'b1;
                next_st   = StLoad;
`endif
            end
            StRdReq: begin
                param_ren = core_oh;
                state_d   = StRdWait;
            end
            StRdWait: begin
                ser_load = 1'b1;
                state_d  = StRdSend;
            end
            StRdSend: begin
                rd_valid = 1'b1;
                rd_last  = ser_last && (left_q == '0);
                if (rd_ready) begin
                    ser_step = 1'b1;
                    if (ser_last) begin
                        word_end = 1'b1;
                        next_st  = StRdReq;
                    end
                end
            end
            StDrain: begin
                // Swallow the payload of a rejected write without touching any CSRAM.
                ready_st = 1'b1;
                if (cfg_valid && cfg_ready) begin
                    ser_step = 1'b1;
                    if (ser_last) begin
                        word_end = 1'b1;
                        next_st  = StDrain;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (word_end) begin
            if (left_q == '0) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else begin
                addr_d  = addr_q + 1'b1;
                left_d  = left_q - 1'b1;
                state_d = next_st;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            left_q  <= '0;
            core_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            pdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            core_q  <= core_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pdata_q <= pdata_d;
        end
    end

    // Gated by rst so the handshake is withdrawn in the same cycle reset arrives.
    assign cfg_ready      = ready_st && !rst;
    assign param_addr     = addr_q;
    assign param_data_out = (state_q == StWrite) ? ser_word : pdata_q;
    assign rd_data        = rd_valid ? ser_beat : '0;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign err            = err_q;

endmodule
